// File: rtl/trng_whitener.sv
// Von Neumann debiaser for the raw random-bit source: packs debiased bits MSB-first into
// bytes, buffers them in a small valid/ready FIFO and runs a sticky repetition-count health test.
module trng_whitener #(
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     raw_bit,
    input  logic                     raw_valid,
    input  logic                     clear_fail,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     health_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [RW-1:0] REP_C   = RW'(REP_LIMIT);

    typedef enum logic {EMPTY, HAVE_FIRST} pair_state_t;

    pair_state_t    state, state_next;
    logic           first_bit, first_next;
    logic           emit;
    logic [2:0]     bit_cnt;
    logic [6:0]     shift;
    logic           push, push_ok, pop;
    logic [7:0]     push_data;
    logic [RW-1:0]  rep_cnt, rep_next;
    logic           last_bit;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;

    // Repetition counter: a zero count means no reference bit since reset/clear.
    always_comb begin
        rep_next = rep_cnt;
        if (rep_cnt == '0 || raw_bit != last_bit)
            rep_next = RW'(1);
        else if (rep_cnt != REP_C)
            rep_next = rep_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt     <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (clear_fail) begin
            rep_cnt     <= '0;
            health_fail <= 1'b0;
        end else if (raw_valid) begin
            rep_cnt  <= rep_next;
            last_bit <= raw_bit;
            if (rep_next == REP_C)
                health_fail <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            first_bit <= 1'b0;
        end else begin
            state     <= state_next;
            first_bit <= first_next;
        end
    end

    always_comb begin
        state_next = state;
        first_next = first_bit;
        emit       = 1'b0;
        if (clear_fail || !enable) begin
            state_next = EMPTY;
        end else if (raw_valid && !health_fail) begin
            case (state)
                EMPTY: begin
                    first_next = raw_bit;
                    state_next = HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    emit       = (raw_bit != first_bit);
                    state_next = EMPTY;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // The emitted bit is always the first bit of the unequal pair.
    assign push      = emit && (bit_cnt == 3'd7);
    assign push_data = {shift, first_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (clear_fail || !enable) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (emit) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {shift[5:0], first_bit};
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && ((fifo_count != DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok)
                overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_whitener.sv
// Self-checking bench for trng_whitener: table-driven byte vectors, directed corner
// sequences and randomized traffic, all compared against a queue-based reference model.
module tb_trng_whitener;

    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   enable = 1'b0;
    logic                   raw_bit = 1'b0;
    logic                   raw_valid = 1'b0;
    logic                   clear_fail = 1'b0;
    logic                   out_ready = 1'b0;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   health_fail;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_fifo [$];
    bit         m_bits [$];
    bit         m_have_first, m_first, m_last, m_ovf, m_fail;
    int         m_run;

    typedef struct {
        logic [15:0] raw;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [4];

    trng_whitener #(.DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .clear_fail (clear_fail),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_bits.delete();
        m_have_first = 0;
        m_first      = 0;
        m_last       = 0;
        m_ovf        = 0;
        m_fail       = 0;
        m_run        = 0;
    endtask

    // One clock of the reference: pop, then pair/pack using the pre-edge fail flag, then push.
    task automatic model_step(input bit en, input bit rv, input bit rb, input bit rdy, input bit clr);
        bit         old_fail = m_fail;
        bit         pend = 0;
        logic [7:0] pb = 8'h00;
        if (m_fifo.size() > 0 && rdy)
            void'(m_fifo.pop_front());
        if (clr) begin
            m_fail       = 0;
            m_run        = 0;
            m_have_first = 0;
            m_bits.delete();
        end else begin
            if (!en) begin
                m_have_first = 0;
                m_bits.delete();
            end else if (rv && !old_fail) begin
                if (!m_have_first) begin
                    m_first      = rb;
                    m_have_first = 1;
                end else begin
                    m_have_first = 0;
                    if (rb != m_first) begin
                        m_bits.push_back(m_first);
                        if (m_bits.size() == 8) begin
                            foreach (m_bits[i]) pb = {pb[6:0], m_bits[i]};
                            m_bits.delete();
                            pend = 1;
                        end
                    end
                end
            end
            if (rv) begin
                if (m_run == 0 || rb != m_last) m_run = 1;
                else if (m_run < REP_LIMIT) m_run++;
                m_last = rb;
                if (m_run == REP_LIMIT) m_fail = 1;
            end
        end
        if (pend) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(pb);
            else m_ovf = 1;
        end
    endtask

    task automatic checkOutput();
        check("out_valid", int'(out_valid), int'(m_fifo.size() != 0));
        check("out_data", int'(out_data), (m_fifo.size() != 0) ? int'(m_fifo[0]) : 0);
        check("fifo_count", int'(fifo_count), m_fifo.size());
        check("overflow", int'(overflow), int'(m_ovf));
        check("health_fail", int'(health_fail), int'(m_fail));
    endtask

    task automatic applyStimulus(input bit en, input bit rv, input bit rb, input bit rdy, input bit clr);
        enable     = en;
        raw_valid  = rv;
        raw_bit    = rb;
        out_ready  = rdy;
        clear_fail = clr;
        @(posedge clk);
        model_step(en, rv, rb, rdy, clr);
        #1;
        checkOutput();
    endtask

    // Asynchronous reset between clock edges; outputs must clear without waiting for an edge.
    task automatic hard_reset();
        rst_n      = 1'b0;
        raw_valid  = 1'b0;
        clear_fail = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_health_fail", int'(health_fail), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] byte_to_raw(input logic [7:0] b);
        logic [15:0] r = 16'h0;
        for (int i = 7; i >= 0; i--) r = {r[13:0], (b[i] ? 2'b10 : 2'b01)};
        return r;
    endfunction

    task automatic feed_bits(input logic [15:0] raw, input bit rdy_body, input bit rdy_last);
        for (int i = 15; i >= 0; i--)
            applyStimulus(1, 1, raw[i], (i == 0) ? rdy_last : rdy_body, 0);
    endtask

    initial begin
        logic [15:0] r;
        logic [7:0]  seq [4];

        vecs[0] = '{raw: 16'h9A59, exp_byte: 8'hB2};
        vecs[1] = '{raw: 16'hAAAA, exp_byte: 8'hFF};
        vecs[2] = '{raw: 16'h5555, exp_byte: 8'h00};
        vecs[3] = '{raw: 16'h6666, exp_byte: 8'h55};

        #7;
        hard_reset();

        for (int v = 0; v < 4; v++) begin
            feed_bits(vecs[v].raw, 0, 0);
            check("vec_valid", int'(out_valid), 1);
            check("vec_data", int'(out_data), int'(vecs[v].exp_byte));
            applyStimulus(1, 0, 0, 1, 0);
            check("vec_drained", int'(fifo_count), 0);
        end

        // Discarded 00/11 pairs between the useful ones must not disturb packing.
        for (int p = 0; p < 8; p++) begin
            applyStimulus(1, 1, vecs[0].raw[15 - 2 * p], 0, 0);
            applyStimulus(1, 1, vecs[0].raw[14 - 2 * p], 0, 0);
            applyStimulus(1, 1, p[0], 0, 0);
            applyStimulus(1, 1, p[0], 0, 0);
        end
        check("junk_count", int'(fifo_count), 1);
        check("junk_data", int'(out_data), 8'hB2);
        applyStimulus(1, 0, 0, 1, 0);

        hard_reset();
        repeat (5) feed_bits(16'hAAAA, 0, 0);
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_flag", int'(overflow), 1);
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_data", int'(out_data), 8'hFF);
            applyStimulus(1, 0, 0, 1, 0);
        end
        check("ovf_drain_empty", int'(out_valid), 0);

        hard_reset();
        seq = '{8'h22, 8'h33, 8'h44, 8'h55};
        feed_bits(byte_to_raw(8'h11), 0, 0);
        for (int k = 0; k < 3; k++) feed_bits(byte_to_raw(seq[k]), 0, 0);
        feed_bits(byte_to_raw(8'h55), 0, 1);
        check("full_pop_count", int'(fifo_count), 4);
        check("full_pop_ovf", int'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            check("full_pop_order", int'(out_data), int'(seq[k]));
            applyStimulus(1, 0, 0, 1, 0);
        end

        hard_reset();
        for (int k = 1; k <= REP_LIMIT; k++) begin
            applyStimulus(1, 1, 1, 0, 0);
            check("health_trip", int'(health_fail), int'(k == REP_LIMIT));
        end
        for (int k = 0; k < 40; k++) applyStimulus(1, 1, k[0], 0, 0);
        check("health_frozen", int'(fifo_count), 0);
        applyStimulus(1, 0, 0, 0, 1);
        check("health_cleared", int'(health_fail), 0);
        feed_bits(byte_to_raw(8'h3C), 0, 0);
        check("health_resume", int'(out_data), 8'h3C);
        applyStimulus(1, 0, 0, 1, 0);

        hard_reset();
        feed_bits(byte_to_raw(8'hA1), 0, 0);
        feed_bits(byte_to_raw(8'h5E), 0, 0);
        r = byte_to_raw(8'hF0);
        for (int i = 15; i >= 6; i--) applyStimulus(1, 1, r[i], 0, 0);
        check("mid_fifo_count", int'(fifo_count), 2);
        hard_reset();
        feed_bits(byte_to_raw(8'h96), 0, 0);
        check("mid_fresh_count", int'(fifo_count), 1);
        check("mid_fresh_data", int'(out_data), 8'h96);

        hard_reset();
        for (int c = 0; c < 4000; c++) begin
            bit rb;
            if ((c / 500) % 2 == 1) rb = ($urandom % 64) != 0;
            else rb = $urandom % 2;
            applyStimulus(($urandom % 16) != 0, ($urandom % 4) != 0, rb,
                          ($urandom % 3) == 0, ($urandom % 300) == 0);
            if (c == 2100) hard_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
